// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: stall/flush controls, EX forwarding
// selects, mul/div occupancy tracking and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RA_W-1:0]  d_rs1,
    input  logic [RA_W-1:0]  d_rs2,
    input  logic             d_use_rs1,
    input  logic             d_use_rs2,
    input  logic [RA_W-1:0]  e_rs1,
    input  logic [RA_W-1:0]  e_rs2,
    input  logic [RA_W-1:0]  e_rd,
    input  logic             e_mem_read,
    input  logic             e_redirect,
    input  logic             e_md_start,
    input  logic             md_done,
    input  logic [RA_W-1:0]  m_rd,
    input  logic             m_reg_write,
    input  logic [RA_W-1:0]  w_rd,
    input  logic             w_reg_write,
    input  logic             m_mem_req,
    input  logic             m_mem_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_clear,
    output logic             de_en,
    output logic             de_clear,
    output logic             em_en,
    output logic             em_clear,
    output logic             mw_en,
    output logic             mw_clear,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             md_start_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic mem_stall;
    logic load_use;
    logic md_stall;
    logic redirect_apply;

    assign mem_stall = m_mem_req & ~m_mem_ready;

    assign load_use = e_mem_read & (e_rd != '0) &
                      ((d_use_rs1 & (e_rd == d_rs1)) | (d_use_rs2 & (e_rd == d_rs2)));

    assign md_stall = ((state == RUN) & e_md_start) | ((state == MD_BUSY) & ~md_done);

    // A held redirect only takes effect once neither freeze condition is active.
    assign redirect_apply = e_redirect & ~mem_stall & ~md_stall;

    // MD_DONE waits out a memory freeze so the finished op is not restarted.
    assign md_start_o = (state == RUN) & e_md_start & ~reset;

    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] rs,
        input logic [RA_W-1:0] mem_rd,
        input logic            mem_wr,
        input logic [RA_W-1:0] wb_rd,
        input logic            wb_wr
    );
        if (mem_wr && mem_rd != '0 && mem_rd == rs)
            return 2'b10;
        else if (wb_wr && wb_rd != '0 && wb_rd == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign fwd_a = fwd_sel(e_rs1, m_rd, m_reg_write, w_rd, w_reg_write);
    assign fwd_b = fwd_sel(e_rs2, m_rd, m_reg_write, w_rd, w_reg_write);

    always_comb begin
        // NOTE: every output gets a default first so no path through the priority chain infers a latch.
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        fd_clear = 1'b0;
        de_en    = 1'b1;
        de_clear = 1'b0;
        em_en    = 1'b1;
        em_clear = 1'b0;
        mw_en    = 1'b1;
        mw_clear = 1'b0;

        if (mem_stall) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_en    = 1'b0;
            em_en    = 1'b0;
            mw_clear = 1'b1;
        end else if (md_stall) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_en    = 1'b0;
            em_clear = 1'b1;
        end else if (e_redirect) begin
            fd_clear = 1'b1;
            de_clear = 1'b1;
        end else if (load_use) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_clear = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (e_md_start) state_nxt = MD_BUSY;
            MD_BUSY: if (md_done)    state_nxt = mem_stall ? MD_DONE : RUN;
            MD_DONE: if (!mem_stall) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (!pc_en && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect_apply && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expectations, a negedge
// monitor pops and compares; a 4-bit-counter twin checks saturation.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] d_rs1;
        logic [4:0] d_rs2;
        logic       d_use_rs1;
        logic       d_use_rs2;
        logic [4:0] e_rs1;
        logic [4:0] e_rs2;
        logic [4:0] e_rd;
        logic       e_mem_read;
        logic       e_redirect;
        logic       e_md_start;
        logic       md_done;
        logic [4:0] m_rd;
        logic       m_reg_write;
        logic [4:0] w_rd;
        logic       w_reg_write;
        logic       m_mem_req;
        logic       m_mem_ready;
    } in_t;

    typedef struct packed {
        logic [8:0]  ctl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        ms;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    // ctl order: pc_en, fd_en, fd_clear, de_en, de_clear, em_en, em_clear, mw_en, mw_clear
    localparam logic [8:0] NORM = 9'b1_10_10_10_10;
    localparam logic [8:0] MEM  = 9'b0_00_00_00_11;
    localparam logic [8:0] MD   = 9'b0_00_00_11_10;
    localparam logic [8:0] RED  = 9'b1_11_11_10_10;
    localparam logic [8:0] LU   = 9'b0_00_11_10_10;

    logic clk = 1'b0;
    logic reset;
    in_t  vin;

    logic pc_en, fd_en, fd_clear, de_en, de_clear, em_en, em_clear, mw_en, mw_clear;
    logic [1:0]  fwd_a, fwd_b;
    logic        md_start_o;
    logic [31:0] stall_cnt, flush_cnt;

    logic s_pc_en, s_fd_en, s_fd_clear, s_de_en, s_de_clear, s_em_en, s_em_clear, s_mw_en, s_mw_clear;
    logic [1:0] s_fwd_a, s_fwd_b;
    logic       s_md_start_o;
    logic [3:0] s_stall_cnt, s_flush_cnt;

    logic [8:0] ctl;
    assign ctl = {pc_en, fd_en, fd_clear, de_en, de_clear, em_en, em_clear, mw_en, mw_clear};

    always #5 clk = ~clk;

    hazard_ctrl #(.RA_W(5), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .d_rs1(vin.d_rs1), .d_rs2(vin.d_rs2), .d_use_rs1(vin.d_use_rs1), .d_use_rs2(vin.d_use_rs2),
        .e_rs1(vin.e_rs1), .e_rs2(vin.e_rs2), .e_rd(vin.e_rd), .e_mem_read(vin.e_mem_read),
        .e_redirect(vin.e_redirect), .e_md_start(vin.e_md_start), .md_done(vin.md_done),
        .m_rd(vin.m_rd), .m_reg_write(vin.m_reg_write), .w_rd(vin.w_rd), .w_reg_write(vin.w_reg_write),
        .m_mem_req(vin.m_mem_req), .m_mem_ready(vin.m_mem_ready),
        .pc_en(pc_en), .fd_en(fd_en), .fd_clear(fd_clear), .de_en(de_en), .de_clear(de_clear),
        .em_en(em_en), .em_clear(em_clear), .mw_en(mw_en), .mw_clear(mw_clear),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .md_start_o(md_start_o),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.RA_W(5), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset),
        .d_rs1(vin.d_rs1), .d_rs2(vin.d_rs2), .d_use_rs1(vin.d_use_rs1), .d_use_rs2(vin.d_use_rs2),
        .e_rs1(vin.e_rs1), .e_rs2(vin.e_rs2), .e_rd(vin.e_rd), .e_mem_read(vin.e_mem_read),
        .e_redirect(vin.e_redirect), .e_md_start(vin.e_md_start), .md_done(vin.md_done),
        .m_rd(vin.m_rd), .m_reg_write(vin.m_reg_write), .w_rd(vin.w_rd), .w_reg_write(vin.w_reg_write),
        .m_mem_req(vin.m_mem_req), .m_mem_ready(vin.m_mem_ready),
        .pc_en(s_pc_en), .fd_en(s_fd_en), .fd_clear(s_fd_clear), .de_en(s_de_en), .de_clear(s_de_clear),
        .em_en(s_em_en), .em_clear(s_em_clear), .mw_en(s_mw_en), .mw_clear(s_mw_clear),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .md_start_o(s_md_start_o),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    exp_t   sb_q[$];
    int     total = 0;
    int     bad   = 0;
    logic [31:0] exp_stall = 0;
    logic [31:0] exp_flush = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat4(input logic [31:0] v);
        return (v > 32'd15) ? 32'd15 : v;
    endfunction

    // Monitor: outputs are combinational, so every cycle presents a result at the negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("ctl",         32'(ctl),         32'(e.ctl));
                check("fwd_a",       32'(fwd_a),       32'(e.fa));
                check("fwd_b",       32'(fwd_b),       32'(e.fb));
                check("md_start_o",  32'(md_start_o),  32'(e.ms));
                check("stall_cnt",   stall_cnt,        e.sc);
                check("flush_cnt",   flush_cnt,        e.fc);
                check("stall_cnt4",  32'(s_stall_cnt), sat4(e.sc));
                check("flush_cnt4",  32'(s_flush_cnt), sat4(e.fc));
            end
        end
    end

    // Drive one cycle at posedge+1, push its expectation, then advance the counter model.
    task automatic step(input in_t v, input logic [8:0] c, input logic [1:0] fa,
                        input logic [1:0] fb, input logic ms);
        exp_t e;
        vin = v;
        e.ctl = c; e.fa = fa; e.fb = fb; e.ms = ms;
        e.sc = exp_stall; e.fc = exp_flush;
        sb_q.push_back(e);
        if (!reset) begin
            if (!c[8]) exp_stall++;
            if (c == RED) exp_flush++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_step();
        reset = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
        step('0, NORM, 2'b00, 2'b00, 1'b0);
    endtask

    initial begin
        in_t v;
        reset = 1'b1;
        vin   = '0;
        @(posedge clk);
        #1;

        // Reset state with idle inputs
        step('0, NORM, 2'b00, 2'b00, 1'b0);
        reset = 1'b0;
        step('0, NORM, 2'b00, 2'b00, 1'b0);

        // Load-use: one bubble, then the load has moved on
        v = '0; v.e_mem_read = 1; v.e_rd = 5; v.d_rs1 = 5; v.d_use_rs1 = 1;
        step(v, LU, 2'b00, 2'b00, 1'b0);
        step('0, NORM, 2'b00, 2'b00, 1'b0);
        // Matching rs2 that is not actually read, and x0 destination: no hazard
        v = '0; v.e_mem_read = 1; v.e_rd = 5; v.d_rs2 = 5; v.d_use_rs2 = 0;
        step(v, NORM, 2'b00, 2'b00, 1'b0);
        v = '0; v.e_mem_read = 1; v.e_rd = 0; v.d_rs1 = 0; v.d_use_rs1 = 1;
        step(v, NORM, 2'b00, 2'b00, 1'b0);
        v = '0; v.e_mem_read = 1; v.e_rd = 9; v.d_rs2 = 9; v.d_use_rs2 = 1;
        step(v, LU, 2'b00, 2'b00, 1'b0);

        // Forwarding priority and x0 suppression
        v = '0; v.e_rs1 = 3; v.e_rs2 = 3; v.m_rd = 3; v.w_rd = 3; v.m_reg_write = 1; v.w_reg_write = 1;
        step(v, NORM, 2'b10, 2'b10, 1'b0);
        v.m_reg_write = 0;
        step(v, NORM, 2'b01, 2'b01, 1'b0);
        v = '0; v.e_rs1 = 0; v.m_rd = 0; v.w_rd = 0; v.m_reg_write = 1; v.w_reg_write = 1;
        v.e_rs2 = 7;
        step(v, NORM, 2'b00, 2'b00, 1'b0);
        v = '0; v.e_rs1 = 4; v.e_rs2 = 7; v.m_rd = 4; v.m_reg_write = 1; v.w_rd = 7; v.w_reg_write = 1;
        v.m_mem_req = 1;
        step(v, MEM, 2'b10, 2'b01, 1'b0);

        // Redirect wins over load-use
        v = '0; v.e_mem_read = 1; v.e_rd = 5; v.d_rs1 = 5; v.d_use_rs1 = 1; v.e_redirect = 1;
        step(v, RED, 2'b00, 2'b00, 1'b0);

        // Memory wait for 3 cycles
        v = '0; v.m_mem_req = 1; v.m_mem_ready = 0;
        for (int i = 0; i < 3; i++) step(v, MEM, 2'b00, 2'b00, 1'b0);
        v.m_mem_ready = 1;
        step(v, NORM, 2'b00, 2'b00, 1'b0);

        // Redirect held under a memory freeze applies once it clears
        v = '0; v.e_redirect = 1; v.m_mem_req = 1;
        step(v, MEM, 2'b00, 2'b00, 1'b0);
        step(v, MEM, 2'b00, 2'b00, 1'b0);
        v.m_mem_req = 0;
        step(v, RED, 2'b00, 2'b00, 1'b0);

        // Mul/div with md_done during a memory freeze
        v = '0; v.e_md_start = 1;
        step(v, MD, 2'b00, 2'b00, 1'b1);                 // cycle 0: start pulse
        for (int i = 1; i <= 3; i++) step(v, MD, 2'b00, 2'b00, 1'b0);
        v.md_done = 1; v.m_mem_req = 1;
        step(v, MEM, 2'b00, 2'b00, 1'b0);                // cycle 4 -> MD_DONE
        v.md_done = 0;
        step(v, MEM, 2'b00, 2'b00, 1'b0);                // cycle 5 held in MD_DONE
        v.m_mem_req = 0;
        step(v, NORM, 2'b00, 2'b00, 1'b0);               // cycle 6: advance, no restart
        step(v, MD, 2'b00, 2'b00, 1'b1);                 // cycle 7: back in RUN, new op
        v.md_done = 1;
        step(v, NORM, 2'b00, 2'b00, 1'b0);
        step('0, NORM, 2'b00, 2'b00, 1'b0);

        // Long freeze pushes the 4-bit counter into saturation
        v = '0; v.m_mem_req = 1;
        for (int i = 0; i < 20; i++) step(v, MEM, 2'b00, 2'b00, 1'b0);
        step('0, NORM, 2'b00, 2'b00, 1'b0);

        // Async reset mid MD_BUSY, pending md_done ignored afterwards
        v = '0; v.e_md_start = 1;
        step(v, MD, 2'b00, 2'b00, 1'b1);
        step(v, MD, 2'b00, 2'b00, 1'b0);
        reset_step();
        v = '0; v.md_done = 1;
        step(v, NORM, 2'b00, 2'b00, 1'b0);
        reset = 1'b0;
        step(v, NORM, 2'b00, 2'b00, 1'b0);
        v = '0; v.e_md_start = 1;
        step(v, MD, 2'b00, 2'b00, 1'b1);
        v.md_done = 1;
        step(v, NORM, 2'b00, 2'b00, 1'b0);
        step('0, NORM, 2'b00, 2'b00, 1'b0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
